acc_readout: RTL and testbench
==============================

ACC_READOUT -- requirements
Module: acc_readout

Interface
REQ-001 Parameters: none; depth fixed at 4 entries, data width fixed at 12 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 sum_in  input  12  accumulator result from the write side.
REQ-005 ld_in  input  1  write strobe; sum_in is valid in the same cycle.
REQ-006 rd_data  output  12  head-of-queue result, first-word-fall-through.
REQ-007 rd_valid  output  1  rd_data holds an unread entry.
REQ-008 rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-009 count  output  3  number of stored entries, 0..4.
REQ-010 full  output  1  count == 4.
REQ-011 empty  output  1  count == 0.
REQ-012 drop  output  1  one-cycle pulse: a write was discarded last cycle.
REQ-013 drop_cnt  output  8  discarded-write counter (see Configuration).

Function
REQ-014 Storage: 4x12 circular buffer; 2-bit write and read pointers that wrap 3 -> 0.
REQ-015 Push: the block SHALL accept a push when ld_in=1 and (full=0, or a pop occurs in the same cycle).
REQ-016 Pop: the block SHALL pop when rd_valid=1 and rd_ready=1; the read pointer advances on that edge.
REQ-017 rd_valid SHALL equal ~empty; rd_data SHALL equal mem[rd_ptr], registered storage with no combinational path from sum_in.
REQ-018 Latency: a push into an empty buffer SHALL raise rd_valid on the next cycle, with rd_data = the pushed value.
REQ-019 Simultaneous push and pop:
  - count unchanged.
  - Both pointers advance.
  - Accepted even when full=1.
REQ-020 Simultaneous push and pop when empty: the pop SHALL NOT occur (rd_valid=0); the push proceeds normally.
REQ-021 Full with ld_in=1 and no pop:
  - Write discarded; stored entries unchanged.
  - drop=1 on the next cycle.
REQ-022 rd_ready while empty SHALL be ignored; pointers and count unchanged.
REQ-023 rd_data while rd_valid=0 is don't-care; the bench SHALL NOT check it.
REQ-024 count, full, empty and drop SHALL be registered outputs, updated on the same edge as the pointers.
REQ-025 Ordering: outputs SHALL leave in strict arrival order; no reordering and no duplication.

Reset
REQ-026 When rst_n=0 at a rising edge, the block SHALL set the following to zero:
  - read and write pointers;
  - count, drop, drop_cnt;
  - full=0, empty=1, rd_valid=0.
REQ-027 Reset has priority over a simultaneous push or pop; both are lost.
REQ-028 Memory contents are not reset; they are invisible while empty.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries within that single edge.

Configuration
REQ-030 Macro ACC_READOUT_DROP_CNT_EN: when defined, drop_cnt SHALL increment by 1 on each discarded write and saturate at 255; only reset clears it.
REQ-031 Without ACC_READOUT_DROP_CNT_EN:
  - drop_cnt SHALL be tied to 8'd0 and no counter registers are built.
  - The drop pulse is unaffected.

Verification
REQ-032 Reset, then push 12'h0A5 with rd_ready=0 -> next cycle: rd_valid=1, rd_data=12'h0A5, count=1, empty=0.
REQ-033 Push 12'h001..12'h004 on consecutive cycles with rd_ready=0 -> full=1, count=4; then hold rd_ready=1 -> pops 001,002,003,004 in order, ending with empty=1.
REQ-034 Full buffer plus push 12'hFFF with no pop:
  - Next cycle: drop=1 for exactly one cycle, count=4.
  - Drained sequence excludes 12'hFFF.
  - drop_cnt=1 with the macro defined, 0 without it.
REQ-035 Full buffer, ld_in=1 with sum_in=12'h123 and rd_ready=1 in the same cycle -> count stays 4, drop=0, and 12'h123 is the last entry drained.
REQ-036 Push 3 entries, then rst_n=0 in the same cycle as ld_in=1 -> next cycle: count=0, empty=1, rd_valid=0; the next push appears alone.
REQ-037 Macro defined, 300 discarded writes -> drop_cnt=255 and holds that value.

Source files
------------

// File: rtl/acc_readout_if.sv
// Handshake bundle for acc_readout: write strobe/data in, FWFT read port out,
// plus occupancy and drop status.
interface acc_readout_if;
    logic [11:0] sum_in;
    logic        ld_in;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        drop;
    logic [7:0]  drop_cnt;

    // Producer/consumer side
    modport master (
        output sum_in, ld_in, rd_ready,
        input  rd_data, rd_valid, count, full, empty, drop, drop_cnt
    );

    // Buffer side
    modport slave (
        input  sum_in, ld_in, rd_ready,
        output rd_data, rd_valid, count, full, empty, drop, drop_cnt
    );
endinterface

// File: rtl/acc_readout.sv
// acc_readout: 4-entry x 12-bit first-word-fall-through queue for accumulator
// results. A write into a full queue is discarded unless a pop happens in the
// same cycle; a discarded write produces a one-cycle drop pulse.
// Optional macro ACC_READOUT_DROP_CNT_EN builds a saturating 8-bit count of
// discarded writes; without it drop_cnt is constant zero.
module acc_readout (
    input  logic          clk,
    input  logic          rst_n,
    acc_readout_if.slave  bus
);
    logic [11:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count_q;
    logic        full_q;
    logic        empty_q;
    logic        drop_q;

    logic        pop;
    logic        push;
    logic        drop_evt;
    logic [2:0]  count_nxt;

    // Handshake decode: a pop frees a slot, so a full queue still accepts a
    // push in the same cycle; a pop on an empty queue never happens.
    always_comb begin
        pop       = 1'b0;
        push      = 1'b0;
        drop_evt  = 1'b0;
        count_nxt = count_q;
        pop       = !empty_q && bus.rd_ready;
        push      = bus.ld_in && (!full_q || pop);
        drop_evt  = bus.ld_in && !push;
        case ({push, pop})
            2'b10:   count_nxt = count_q + 3'd1;
            2'b01:   count_nxt = count_q - 3'd1;
            default: count_nxt = count_q;
        endcase
    end

    // Pointers and registered status; reset wins over any push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count_q <= 3'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count_q <= count_nxt;
            full_q  <= (count_nxt == 3'd4);
            empty_q <= (count_nxt == 3'd0);
            drop_q  <= drop_evt;
        end
    end

    // Storage is not reset; stale words are hidden behind empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= bus.sum_in;
    end

    assign bus.rd_data  = mem[rd_ptr];
    assign bus.rd_valid = !empty_q;
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.drop     = drop_q;

`ifdef ACC_READOUT_DROP_CNT_EN
    logic [7:0] dcnt_q;

    // Saturating tally of discarded writes; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)                           dcnt_q <= 8'd0;
        else if (drop_evt && dcnt_q != 8'hFF) dcnt_q <= dcnt_q + 8'd1;
    end

    assign bus.drop_cnt = dcnt_q;
`else
    assign bus.drop_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_acc_readout.sv
// Self-checking bench for acc_readout: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_acc_readout;
    logic clk;
    logic rst_n;
    acc_readout_if bus ();

    acc_readout dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ACC_READOUT_DROP_CNT_EN
    localparam bit DCNT_EN = 1'b1;
`else
    localparam bit DCNT_EN = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a plain queue of words plus drop bookkeeping.
    int q[$];
    int mdl_drop = 0;
    int mdl_dcnt = 0;
    bit mdl_ok   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            mdl_drop = 0;
            mdl_dcnt = 0;
            mdl_ok   = 1'b1;
        end else if (mdl_ok) begin
            bit pop_m, push_m;
            pop_m  = (q.size() > 0) && bus.rd_ready;
            push_m = bus.ld_in && ((q.size() < 4) || pop_m);
            if (pop_m)  void'(q.pop_front());
            if (push_m) q.push_back(int'(bus.sum_in));
            mdl_drop = (bus.ld_in && !push_m) ? 1 : 0;
            if (mdl_drop == 1 && DCNT_EN && mdl_dcnt < 255) mdl_dcnt++;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("m_count",    32'(bus.count),    32'(q.size()));
            chk("m_full",     32'(bus.full),     32'(q.size() == 4));
            chk("m_empty",    32'(bus.empty),    32'(q.size() == 0));
            chk("m_rd_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("m_rd_data", 32'(bus.rd_data), 32'(q[0]));
            chk("m_drop",     32'(bus.drop),     32'(mdl_drop));
            chk("m_drop_cnt", 32'(bus.drop_cnt), 32'(mdl_dcnt));
        end
    end

    task automatic step(input logic l, input logic [11:0] d, input logic r, input logic rs);
        rst_n        = rs;
        bus.ld_in    = l;
        bus.sum_in   = d;
        bus.rd_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 12'h0, 1'b0, 1'b0);
        step(1'b0, 12'h0, 1'b0, 1'b1);
    endtask

    task automatic fill4();
        for (int i = 1; i <= 4; i++) step(1'b1, 12'(i), 1'b0, 1'b1);
    endtask

    task automatic pop_expect(input string nm, input logic [11:0] exp);
        chk({nm, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({nm, "_data"},  32'(bus.rd_data),  32'(exp));
        step(1'b0, 12'h0, 1'b1, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; bus.ld_in = 1'b0; bus.sum_in = '0; bus.rd_ready = 1'b0;
        do_reset();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full),  32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_drop",  32'(bus.drop),  32'd0);
        chk("rst_dcnt",  32'(bus.drop_cnt), 32'd0);

        // Single push latency
        step(1'b1, 12'h0A5, 1'b0, 1'b1);
        chk("lat_valid", 32'(bus.rd_valid), 32'd1);
        chk("lat_data",  32'(bus.rd_data),  32'h0A5);
        chk("lat_count", 32'(bus.count),    32'd1);
        chk("lat_empty", 32'(bus.empty),    32'd0);

        // Fill then drain in order
        do_reset();
        fill4();
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_count", 32'(bus.count), 32'd4);
        for (int i = 1; i <= 4; i++) pop_expect("drain", 12'(i));
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Discarded write on full
        do_reset();
        fill4();
        step(1'b1, 12'hFFF, 1'b0, 1'b1);
        chk("drop_pulse", 32'(bus.drop),     32'd1);
        chk("drop_count", 32'(bus.count),    32'd4);
        chk("drop_dcnt",  32'(bus.drop_cnt), DCNT_EN ? 32'd1 : 32'd0);
        step(1'b0, 12'h0, 1'b0, 1'b1);
        chk("drop_once",  32'(bus.drop),     32'd0);
        for (int i = 1; i <= 4; i++) pop_expect("drop_drain", 12'(i));
        chk("drop_empty", 32'(bus.empty), 32'd1);

        // Push and pop together while full
        fill4();
        step(1'b1, 12'h123, 1'b1, 1'b1);
        chk("pp_count", 32'(bus.count), 32'd4);
        chk("pp_drop",  32'(bus.drop),  32'd0);
        pop_expect("pp_drain", 12'h002);
        pop_expect("pp_drain", 12'h003);
        pop_expect("pp_drain", 12'h004);
        pop_expect("pp_drain", 12'h123);
        chk("pp_empty", 32'(bus.empty), 32'd1);

        // Push and rd_ready together while empty: push only
        step(1'b1, 12'h3C3, 1'b1, 1'b1);
        chk("pe_count", 32'(bus.count),   32'd1);
        chk("pe_data",  32'(bus.rd_data), 32'h3C3);
        pop_expect("pe_drain", 12'h3C3);

        // Reset mid-operation with a concurrent push
        for (int i = 1; i <= 3; i++) step(1'b1, 12'(i), 1'b0, 1'b1);
        step(1'b1, 12'h777, 1'b0, 1'b0);
        chk("mr_count", 32'(bus.count),    32'd0);
        chk("mr_empty", 32'(bus.empty),    32'd1);
        chk("mr_valid", 32'(bus.rd_valid), 32'd0);
        step(1'b1, 12'h456, 1'b0, 1'b1);
        chk("mr_count1", 32'(bus.count), 32'd1);
        pop_expect("mr_alone", 12'h456);
        chk("mr_empty2", 32'(bus.empty), 32'd1);

        // Saturation of the drop counter
        do_reset();
        fill4();
        for (int i = 0; i < 300; i++) step(1'b1, 12'hFFF, 1'b0, 1'b1);
        chk("sat_dcnt", 32'(bus.drop_cnt), DCNT_EN ? 32'd255 : 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 12'hFFF, 1'b0, 1'b1);
        chk("sat_hold", 32'(bus.drop_cnt), DCNT_EN ? 32'd255 : 32'd0);

        // Random traffic against the model, phases bias fill vs drain
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int ph, lp, rp;
            ph = (i / 150) % 3;
            lp = (ph == 0) ? 85 : (ph == 1) ? 50 : 20;
            rp = (ph == 0) ? 20 : (ph == 1) ? 50 : 85;
            step(($urandom_range(99) < lp), 12'($urandom), ($urandom_range(99) < rp),
                 ($urandom_range(199) != 0));
        end
        step(1'b0, 12'h0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
